// File: rtl/dvi_timing_ctrl.sv
// DVI raster timing: divides the serial bit clock down to a pixel strobe that stays
// aligned to the serializer word load, and sequences h/v counters with registered sync/DE.
module dvi_timing_ctrl #(
  parameter int BIT_DIV   = 10,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             pix_stb_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_STB  = DIV_W'(BIT_DIV - 2);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_stb;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CNT_W-1:0] w_h_ld;
  logic [CNT_W-1:0] w_v_ld;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_de;

  // The divider never stops outside reset so the strobe phase tracks the serializer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_stb = !rst_i && (r_div == DIV_STB);

  // Coordinates to present next: (0,0) when starting from IDLE, else the raster successor.
  always_comb begin
    w_h_wrap = (r_h == H_LAST);
    w_v_wrap = (r_v == V_LAST);
    w_h_ld   = '0;
    w_v_ld   = '0;
    if (r_state == S_RUN) begin
      w_h_ld = w_h_wrap ? '0 : r_h + CNT_W'(1);
      if (!w_h_wrap) begin
        w_v_ld = r_v;
      end else begin
        w_v_ld = w_v_wrap ? '0 : r_v + CNT_W'(1);
      end
    end
    w_hs_act = (w_h_ld >= HS_START) && (w_h_ld < HS_END);
    w_vs_act = (w_v_ld >= VS_START) && (w_v_ld < VS_END);
    w_de     = (w_h_ld < H_ACT) && (w_v_ld < V_ACT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_h           <= '0;
      r_v           <= '0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_stb) begin
      if (en_i) begin
        r_state       <= S_RUN;
        r_h           <= w_h_ld;
        r_v           <= w_v_ld;
        r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
        r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
        r_de          <= w_de;
        r_line_start  <= (w_h_ld == '0);
        r_frame_start <= (w_h_ld == '0) && (w_v_ld == '0);
      end else begin
        // Dropping enable abandons the frame; the next start is always at (0,0).
        r_state       <= S_IDLE;
        r_h           <= '0;
        r_v           <= '0;
        r_hsync       <= ~HSYNC_POL;
        r_vsync       <= ~VSYNC_POL;
        r_de          <= 1'b0;
        r_line_start  <= 1'b0;
        r_frame_start <= 1'b0;
      end
    end
  end

  assign pix_stb_o     = w_stb;
  assign hsync_o       = r_hsync;
  assign vsync_o       = r_vsync;
  assign de_o          = r_de;
  assign x_o           = r_h;
  assign y_o           = r_v;
  assign line_start_o  = r_line_start;
  assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Self-checking bench for dvi_timing_ctrl on a small 8x6 raster: linear pixel-index
// reference model checked every cycle, plus hand-computed cadence expectations.
module tb_dvi_timing_ctrl;
  localparam int BD = 10;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          pix_stb, hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] x, y;

  dvi_timing_ctrl #(
    .BIT_DIV(BD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pix_stb_o(pix_stb),
    .hsync_o(hsync), .vsync_o(vsync), .de_o(de), .x_o(x), .y_o(y),
    .line_start_o(line_start), .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: cycles since reset release, plus a single linear pixel index.
  int m_cyc   = 0;
  bit m_run   = 0;
  int m_p     = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc   = 0;
      m_run   = 0;
      m_p     = 0;
      m_valid = 1;
    end else begin
      if (m_cyc % BD == BD - 2) begin
        if (en) begin
          m_p   = m_run ? (m_p + 1) % (HT * VT) : 0;
          m_run = 1;
        end else begin
          m_run = 0;
          m_p   = 0;
        end
      end
      m_cyc++;
    end
  end

  int eh, ev;
  bit e_stb, e_hs, e_vs, e_de, e_ls, e_fs;

  always @(negedge clk) begin
    if (m_valid) begin
      eh    = m_run ? m_p % HT : 0;
      ev    = m_run ? m_p / HT : 0;
      e_stb = !rst && (m_cyc % BD == BD - 2);
      e_hs  = !(m_run && eh >= HA + HF && eh < HA + HF + HS);
      e_vs  = !(m_run && ev >= VA + VF && ev < VA + VF + VS);
      e_de  = m_run && eh < HA && ev < VA;
      e_ls  = m_run && eh == 0;
      e_fs  = m_run && m_p == 0;
      n_tests++;
      if (pix_stb !== e_stb || hsync !== e_hs || vsync !== e_vs || de !== e_de ||
          line_start !== e_ls || frame_start !== e_fs ||
          x !== CW'(eh) || y !== CW'(ev)) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got stb=%b hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d required stb=%b hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
                 $time, pix_stb, hsync, vsync, de, line_start, frame_start, x, y,
                 e_stb, e_hs, e_vs, e_de, e_ls, e_fs, eh, ev);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int next_stb(input int c);
    return c + ((BD - 2 - (c % BD)) + BD) % BD;
  endfunction

  int fs_rise[$];
  int ls_rise[$];
  int stb_at[$];
  int vs_low, hs_low_line0, de_frame0;
  bit prev_fs, prev_ls, found;
  int k, c0;

  initial begin
    // Phase 1: reset release with enable held high, one-plus frames free-running.
    rst = 1; en = 1;
    repeat (3) tick();
    rst = 0;
    prev_fs = 0; prev_ls = 0;
    vs_low = 0; hs_low_line0 = 0; de_frame0 = 0;
    for (int c = 0; c < 1000; c++) begin
      if (pix_stb) stb_at.push_back(c);
      if (frame_start && !prev_fs) fs_rise.push_back(c);
      if (line_start && !prev_ls) ls_rise.push_back(c);
      prev_fs = frame_start; prev_ls = line_start;
      if (fs_rise.size() == 1) begin
        if (!vsync) vs_low++;
        if (de) de_frame0++;
      end
      if (c >= 9 && c < 89 && !hsync) hs_low_line0++;
      if (c == 9) begin
        chk("c9_x", x, 0);
        chk("c9_y", y, 0);
        chk("c9_de", de, 1);
        chk("c9_frame_start", frame_start, 1);
        chk("c9_hsync", hsync, 1);
        chk("c9_vsync", vsync, 1);
      end
      tick();
    end
    chk("stb_first", stb_at.size() > 0 ? stb_at[0] : -1, 8);
    chk("stb_second", stb_at.size() > 1 ? stb_at[1] : -1, 18);
    chk("frame_start_first", fs_rise.size() > 0 ? fs_rise[0] : -1, 9);
    chk("frame_period", fs_rise.size() > 1 ? fs_rise[1] - fs_rise[0] : -1, 480);
    chk("line_period", ls_rise.size() > 1 ? ls_rise[1] - ls_rise[0] : -1, 80);
    chk("vsync_low_cycles", vs_low, 80);
    chk("hsync_low_line0", hs_low_line0, 20);
    chk("de_high_frame0", de_frame0, 120);

    // Phase 2: drop enable at h=2, v=1 for 100 cycles, then re-enable.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (x == 2 && y == 1) found = 1;
      else tick();
    end
    chk("reach_h2_v1", found, 1);
    en = 0;
    c0 = m_cyc;
    k = next_stb(c0);
    while (m_cyc < k) tick();
    chk("drop_pre_x", x, 2);
    tick();
    chk("drop_idle_x", x, 0);
    chk("drop_idle_y", y, 0);
    chk("drop_idle_de", de, 0);
    chk("drop_idle_hsync", hsync, 1);
    while (m_cyc < c0 + 100) tick();
    en = 1;
    k = next_stb(m_cyc);
    while (m_cyc < k) tick();
    chk("reen_pre_fs", frame_start, 0);
    tick();
    chk("reen_fs", frame_start, 1);
    chk("reen_x", x, 0);
    chk("reen_y", y, 0);

    // Phase 3: en wiggles only on non-strobe cycles; it must read as 1 throughout.
    for (int i = 0; i < 400; i++) begin
      en = (m_cyc % BD == BD - 2) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    en = 1;

    // Phase 4: random enable flips and occasional short resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1;
        repeat ($urandom_range(1, 3)) tick();
        rst = 0;
      end
      tick();
    end

    // Phase 5: one-cycle reset mid-frame.
    en = 1;
    found = 0;
    for (int i = 0; i < 1500 && !found; i++) begin
      if (x == 3 && y == 2) found = 1;
      else tick();
    end
    chk("reach_h3_v2", found, 1);
    rst = 1;
    tick();
    chk("rst_idle_x", x, 0);
    chk("rst_idle_de", de, 0);
    chk("rst_idle_stb", pix_stb, 0);
    rst = 0;
    stb_at.delete();
    for (int c = 0; c < 12; c++) begin
      if (pix_stb) stb_at.push_back(c);
      if (c == 9) chk("rst_restart_fs", frame_start, 1);
      tick();
    end
    chk("rst_restart_stb", stb_at.size() > 0 ? stb_at[0] : -1, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
